uart_tx_cfg: RTL and testbench

- Parametrised, runtime-configurable UART transmitter; successor to the fixed 8N1 transmitter in the UART subsystem.
- Adds a small input FIFO with a valid/ready handshake.
- Supports 5..DBIT_MAX data bits, none/even/odd parity, and 1 or 2 stop bits, all selectable per frame.
- Shares the oversample tick (s_tick) from the existing baud generator; drives the serial line for image/result streaming to the host.

---
 rtl/uart_tx_cfg_pkg.sv | 33 +++
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_cfg.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_cfg_pkg.sv
// uart_tx_cfg_pkg: shared types for the configurable UART transmitter.
// Parity modes, FSM states, bit-timing default and data-width clamp.
package uart_tx_cfg_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DBIT_MIN   = 5;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  function automatic logic [3:0] clamp_dbits(
    input logic [3:0] d,
    input logic [3:0] dmax
  );
    logic [3:0] r;
    r = d;
    if (d < 4'(DBIT_MIN)) r = 4'(DBIT_MIN);
    else if (d > dmax)    r = dmax;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: small synchronous FIFO with occupancy count.
// Shared between the UART transmit and receive paths.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // pointer and occupancy next state
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rstN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // storage; entries are only read after being counted in
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with input FIFO.
// Frame format (data bits, parity, stop bits) is latched per frame.
module uart_tx_cfg #(
  parameter int OVERSAMPLE = uart_tx_cfg_pkg::OVERSAMPLE,
  parameter int DBIT_MAX   = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic                            s_tick,
  input  logic [DBIT_MAX-1:0]             s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [3:0]                      cfg_dbits,
  input  logic [1:0]                      cfg_parity,
  input  logic                            cfg_stop2,
  output logic                            tx,
  output logic                            tx_done,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  import uart_tx_cfg_pkg::*;

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [3:0]    DMAX  = 4'(DBIT_MAX);
  localparam logic [CW-1:0] TLAST = CW'(OVERSAMPLE - 1);

  uart_tx_state_t      state_q, state_d;
  logic [CW-1:0]       tick_q, tick_d;
  logic [3:0]          bit_q, bit_d;
  logic [3:0]          nbits_q, nbits_d;
  logic                stop_q, stop_d;
  logic                stop2_q, stop2_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic [DBIT_MAX-1:0] shreg_q, shreg_d;
  logic                tx_q, tx_d;

  logic                push, pop, full, empty;
  logic [DBIT_MAX-1:0] head, mask;
  logic [3:0]          nbits_cfg;
  logic                bit_end;

  uart_sync_fifo #(
    .WIDTH (DBIT_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstN  (rstN),
    .push  (push),
    .wdata (s_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign s_ready = ~full;
  assign push    = s_valid & ~full;
  assign pop     = (state_q == IDLE) & ~empty;
  assign bit_end = s_tick & (tick_q == TLAST);

  // clamp requested width and mask the head word for parity
  always_comb begin
    nbits_cfg = clamp_dbits(cfg_dbits, DMAX);
    for (int i = 0; i < DBIT_MAX; i++) begin
      mask[i] = (4'(i) < nbits_cfg);
    end
  end

  // next-state and frame datapath
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    nbits_d   = nbits_q;
    stop2_d   = stop2_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    shreg_d   = shreg_q;
    if (state_q != IDLE && s_tick) begin
      tick_d = bit_end ? '0 : tick_q + CW'(1);
    end
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d   = START;
          tick_d    = '0;
          bit_d     = '0;
          stop_d    = 1'b0;
          shreg_d   = head;
          nbits_d   = nbits_cfg;
          stop2_d   = cfg_stop2;
          par_en_d  = (cfg_parity == PAR_EVEN) ||
                      (cfg_parity == PAR_ODD);
          par_bit_d = (^(head & mask)) ^
                      (cfg_parity == PAR_ODD);
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 4'd1;
          if (bit_q == nbits_q - 4'd1) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_q) stop_d  = 1'b1;
          else                    state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // line level for the current state
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_q[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_done = rstN & (state_q == STOP) & bit_end &
                   (~stop2_q | stop_q);
  assign busy    = (state_q != IDLE);
  assign tx      = tx_q;

  // state register and frame registers
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      nbits_q   <= '0;
      stop2_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      nbits_q   <= nbits_d;
      stop2_q   <= stop2_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed scoreboard bench for uart_tx_cfg.
// Expected frames are queued at push time and checked on the line.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  localparam int FIFO_DEPTH = 4;
  localparam int OS         = 16;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  n;
  } frame_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       s_tick = 1'b0;
  logic [8:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx;
  logic       tx_done;
  logic       busy;
  logic [2:0] fifo_count;

  int     tests = 0;
  int     fails = 0;
  int     div = 1;
  int     done_cnt = 0;
  int     n_pushed = 0;
  int     max_cnt = 0;
  bit     mon_busy = 0;
  bit     abort_req = 0;
  frame_t exp_q[$];

  uart_tx_cfg #(
    .OVERSAMPLE (OS),
    .DBIT_MAX   (9),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .s_tick     (s_tick),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx         (tx),
    .tx_done    (tx_done),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [8:0] w,
                                        input logic [3:0] d,
                                        input logic [1:0] p,
                                        input logic s2);
    frame_t f;
    int dd, eff, ones, k;
    dd = int'(d);
    eff = (dd < 5) ? 5 : ((dd > 9) ? 9 : dd);
    f.bits = '1;
    f.bits[0] = 1'b0;
    ones = 0;
    k = 1;
    for (int i = 0; i < eff; i++) begin
      f.bits[k] = w[i];
      if (w[i]) ones++;
      k++;
    end
    if (p == 2'b01) begin
      f.bits[k] = (ones % 2 == 1);
      k++;
    end else if (p == 2'b10) begin
      f.bits[k] = (ones % 2 == 0);
      k++;
    end
    k += s2 ? 2 : 1;
    f.n = 5'(k);
    return f;
  endfunction

  // oversample tick, updated just after the active edge
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tc >= div - 1) begin
        tc = 0;
        s_tick = 1'b1;
      end else begin
        tc++;
        s_tick = 1'b0;
      end
    end
  end

  // tx_done pulse counter
  initial begin
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
    end
  end

  // line monitor: pops the scoreboard on each start bit
  initial begin
    frame_t e;
    logic   prev;
    int     t, b, lo, hi;
    bit     ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!abort_req && prev === 1'b1 && tx === 1'b0) begin
        mon_busy = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          b = OS * div;
          t = 0;
          ab = 0;
          for (int i = 0; i < int'(e.n) && !ab; i++) begin
            while (!ab && t < i * b + b / 2) begin
              @(negedge clk);
              t++;
              if (abort_req) ab = 1;
            end
            if (!ab) chk($sformatf("bit%0d", i), 32'(tx), 32'(e.bits[i]));
          end
          while (!ab && tx_done !== 1'b1 && t < int'(e.n) * b + div) begin
            @(negedge clk);
            t++;
            if (abort_req) ab = 1;
          end
          if (!ab) begin
            lo = int'(e.n) * b - div - 1;
            hi = int'(e.n) * b - 2;
            tests++;
            assert (tx_done === 1'b1 && t >= lo && t <= hi) else begin
              fails++;
              $error("FAIL done_time obs=%0d exp=%0d..%0d", t, lo, hi);
            end
            @(negedge clk);
            chk("busy_after_done", 32'(busy), 32'd0);
          end
        end
        mon_busy = 0;
      end
      prev = tx;
    end
  end

  task automatic push_burst(input int n, input logic [8:0] base);
    int k, g;
    k = 0;
    g = 0;
    @(negedge clk);
    while (k < n && g < 4000) begin
      s_data = base + 9'(k);
      s_valid = 1'b1;
      if (s_ready) begin
        exp_q.push_back(make_frame(s_data, cfg_dbits, cfg_parity,
                                   cfg_stop2));
        n_pushed++;
        k++;
      end
      @(negedge clk);
      g++;
      chk("ready_vs_full", 32'(s_ready),
          32'(fifo_count != 3'(FIFO_DEPTH)));
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    s_valid = 1'b0;
    chk("push_all", 32'(k), 32'(n));
  endtask

  task automatic wait_idle(input int lim);
    int c;
    c = 0;
    while (c < lim && !(busy === 1'b0 && fifo_count == 3'd0 &&
           !mon_busy && exp_q.size() == 0)) begin
      @(negedge clk);
      c++;
    end
    chk("idle_reached", 32'(c < lim), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(input int lim);
    int c;
    c = 0;
    while (c < lim && busy !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    chk("busy_seen", 32'(busy), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rstN = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    cfg_dbits = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    rstN = 1'b1;

    push_burst(1, 9'h0A5);
    wait_idle(2000);

    cfg_dbits = 4'd7;
    cfg_parity = 2'b01;
    push_burst(1, 9'h041);
    wait_idle(2000);
    cfg_dbits = 4'd8;
    cfg_parity = 2'b10;
    push_burst(1, 9'h041);
    wait_idle(2000);

    div = 3;
    cfg_dbits = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b1;
    push_burst(1, 9'h03C);
    wait_busy(50);
    repeat (100) @(negedge clk);
    cfg_dbits = 4'd5;
    cfg_parity = 2'b10;
    cfg_stop2 = 1'b0;
    repeat (200) @(negedge clk);
    cfg_dbits = 4'd12;
    wait_idle(6000);
    div = 1;
    cfg_dbits = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    repeat (4) @(negedge clk);

    max_cnt = 0;
    push_burst(6, 9'h001);
    chk("fifo_peak", 32'(max_cnt), 32'(FIFO_DEPTH));
    wait_idle(5000);

    cfg_dbits = 4'd2;
    cfg_parity = 2'b10;
    push_burst(1, 9'h0FF);
    wait_idle(2000);
    cfg_dbits = 4'd12;
    cfg_parity = 2'b01;
    push_burst(1, 9'h1A7);
    wait_idle(2000);
    chk("done_count", 32'(done_cnt), 32'(n_pushed));

    cfg_dbits = 4'd8;
    cfg_parity = 2'b00;
    push_burst(3, 9'h055);
    wait_busy(50);
    repeat (OS * 4) @(negedge clk);
    d0 = done_cnt;
    abort_req = 1'b1;
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_ready", 32'(s_ready), 32'd1);
    repeat (40) @(negedge clk);
    chk("abort_mon", 32'(mon_busy), 32'd0);
    exp_q.delete();
    repeat (60) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_quiet_tx", 32'(tx), 32'd1);
    chk("abort_quiet_busy", 32'(busy), 32'd0);
    abort_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
